// File: rtl/bcd2count_if.sv
// bcd2count_if: request digits in, millisecond count and Start/Busy/Done/Error handshake out
interface bcd2count_if #(parameter int BITS = 29);
  logic            Start;
  logic [3:0]      bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0;
  logic [3:0]      bcd_ms_2, bcd_ms_1, bcd_ms_0;
  logic [BITS-1:0] count;
  logic            Busy, Done, Error;
  modport master (
    output Start, bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0,
           bcd_ms_2, bcd_ms_1, bcd_ms_0,
    input  count, Busy, Done, Error
  );
  modport slave (
    input  Start, bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0,
           bcd_ms_2, bcd_ms_1, bcd_ms_0,
    output count, Busy, Done, Error
  );
endinterface

// File: rtl/bcd2count.sv
// bcd2count: hh:mm:ss.mmm BCD to binary milliseconds, one digit per falling edge via mixed-radix Horner
module bcd2count #(parameter int BITS = 29) (
  input logic        NEclk,
  input logic        Nreset,
  bcd2count_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t          r_state, w_next;
  logic [35:0]     r_digits, w_in;
  logic [BITS-1:0] r_acc, r_count, w_mul, w_step;
  logic [3:0]      r_idx;
  logic            r_error;
  logic [8:0]      w_ok;
  logic            w_valid, w_accept, w_last, w_six;
  assign w_in = {bus.bcd_h_1, bus.bcd_h_0, bus.bcd_min_1, bus.bcd_min_0, bus.bcd_s_1,
                 bus.bcd_s_0, bus.bcd_ms_2, bus.bcd_ms_1, bus.bcd_ms_0};
  for (genvar g = 0; g < 9; g++) begin : g_ok
    assign w_ok[g] = w_in[4*g +: 4] <= 4'd9;
  end
  assign w_valid  = &w_ok && bus.bcd_min_1 <= 4'd5 && bus.bcd_s_1 <= 4'd5;
  assign w_accept = bus.Start && r_state != CONV;
  assign w_last   = r_idx == 4'd8;
  // min_1 and s_1 steps are radix 6; all others radix 10
  assign w_six    = r_idx == 4'd2 || r_idx == 4'd4;
  assign w_mul    = w_six ? (r_acc << 2) + (r_acc << 1) : (r_acc << 3) + (r_acc << 1);
  assign w_step   = w_mul + {{(BITS-4){1'b0}}, r_digits[35:32]};
  always_comb begin
    w_next = w_accept ? (w_valid ? CONV : DONE) : r_state == CONV ? (w_last ? DONE : CONV) : IDLE;
  end
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      r_digits <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else if (w_accept) begin
      r_digits <= w_in;
      r_acc    <= '0;
      r_idx    <= '0;
      r_error  <= !w_valid;
    end else if (r_state == CONV) begin
      r_digits <= r_digits << 4;
      r_acc    <= w_step;
      r_idx    <= r_idx + 4'd1;
      if (w_last) r_count <= w_step;
    end
  end
  assign bus.count = r_count;
  assign bus.Busy  = r_state == CONV;
  assign bus.Done  = r_state == DONE;
  assign bus.Error = r_error;
endmodule

// File: tb/tb_bcd2count.sv
// tb_bcd2count: directed vectors for the BCD-to-millisecond converter, sampled on rising edges
module tb_bcd2count;
  logic NEclk, Nreset;
  int   n_tests = 0, n_fail = 0;
  bcd2count_if #(.BITS(29)) bus();
  bcd2count #(.BITS(29)) dut (.NEclk(NEclk), .Nreset(Nreset), .bus(bus));
  initial begin
    NEclk = 1'b1;
    forever #5 NEclk = ~NEclk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic set_bcd(input logic [35:0] v);
    {bus.bcd_h_1, bus.bcd_h_0, bus.bcd_min_1, bus.bcd_min_0, bus.bcd_s_1,
     bus.bcd_s_0, bus.bcd_ms_2, bus.bcd_ms_1, bus.bcd_ms_0} = v;
  endtask
  task automatic step;
    @(negedge NEclk);
    @(posedge NEclk);
  endtask
  task automatic run_valid(input logic [35:0] v, input logic [31:0] exp);
    set_bcd(v);
    bus.Start = 1'b1;
    step;
    bus.Start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check("busy_hi", bus.Busy, 1);
      check("done_lo", bus.Done, 0);
      step;
    end
    check("busy_end", bus.Busy, 0);
    check("done_hi", bus.Done, 1);
    check("count", bus.count, exp);
    check("error_lo", bus.Error, 0);
    step;
    check("done_drop", bus.Done, 0);
  endtask
  task automatic run_invalid(input logic [35:0] v, input logic [31:0] keep);
    set_bcd(v);
    bus.Start = 1'b1;
    step;
    bus.Start = 1'b0;
    check("inv_done", bus.Done, 1);
    check("inv_error", bus.Error, 1);
    check("inv_busy", bus.Busy, 0);
    check("inv_count", bus.count, keep);
    step;
    check("inv_done_drop", bus.Done, 0);
    check("inv_busy2", bus.Busy, 0);
    check("inv_error_keep", bus.Error, 1);
  endtask
  initial begin
    int n_done, done_at, first, second, idle;
    logic [31:0] got;
    Nreset = 1'b0;
    bus.Start = 1'b0;
    set_bcd('0);
    @(posedge NEclk);
    check("rst_count", bus.count, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_error", bus.Error, 0);
    Nreset = 1'b1;
    step;
    run_valid(36'h010203456, 3723456);
    run_valid(36'h995959999, 359999999);
    run_valid(36'h000000000, 0);
    run_valid(36'h000001000, 1000);
    run_invalid(36'h006000000, 1000);
    run_invalid(36'h00000000A, 1000);
    run_valid(36'h000002000, 2000);
    // second Start with new digits during CONV must be ignored
    set_bcd(36'h123456789);
    bus.Start = 1'b1;
    step;
    bus.Start = 1'b0;
    step;
    step;
    set_bcd(36'h995959999);
    bus.Start = 1'b1;
    step;
    bus.Start = 1'b0;
    n_done = 0;
    done_at = -1;
    got = '0;
    for (int c = 3; c < 15; c++) begin
      if (bus.Done) begin
        n_done++;
        done_at = c;
        got = bus.count;
      end
      step;
    end
    check("ign_ndone", n_done, 1);
    check("ign_done_at", done_at, 9);
    check("ign_count", got, 45296789);
    // asynchronous reset mid-conversion
    set_bcd(36'h010203456);
    bus.Start = 1'b1;
    step;
    bus.Start = 1'b0;
    for (int i = 0; i < 5; i++) step;
    check("pre_rst_busy", bus.Busy, 1);
    Nreset = 1'b0;
    #1;
    check("arst_count", bus.count, 0);
    check("arst_busy", bus.Busy, 0);
    check("arst_done", bus.Done, 0);
    check("arst_error", bus.Error, 0);
    #1 Nreset = 1'b1;
    @(posedge NEclk);
    for (int i = 0; i < 6; i++) step;
    check("post_rst_busy", bus.Busy, 0);
    check("post_rst_count", bus.count, 0);
    run_valid(36'h000001000, 1000);
    // Start held high: Done every 10 cycles, never idle
    set_bcd(36'h000000001);
    bus.Start = 1'b1;
    first = -1;
    second = -1;
    n_done = 0;
    idle = 0;
    for (int c = 0; c < 25; c++) begin
      step;
      if (bus.Done) begin
        n_done++;
        if (first < 0) first = c;
        else second = c;
      end
      if (!bus.Busy && !bus.Done) idle++;
    end
    bus.Start = 1'b0;
    check("held_ndone", n_done, 2);
    check("held_first", first, 9);
    check("held_second", second, 19);
    check("held_idle", idle, 0);
    for (int i = 0; i < 12; i++) step;
    check("held_count", bus.count, 1);
    check("held_busy_end", bus.Busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
